// File: rtl/simd_pkg.sv
// Shared SIMD datapath definitions: serializer state encoding and the
// shift-then-saturate requantization used here and by the writeback path.
package simd_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

    // Widest element the saturation helper handles; callers sign-extend into it.
    localparam int SAT_MAX_W = 64;

    function automatic logic signed [SAT_MAX_W-1:0] shift_sat(
        input logic signed [SAT_MAX_W-1:0] x,
        input int                          shift,
        input int                          w_q
    );
        logic signed [SAT_MAX_W-1:0] y;
        logic signed [SAT_MAX_W-1:0] hi;
        logic signed [SAT_MAX_W-1:0] lo;
        y  = x >>> shift;
        hi = (64'sd1 <<< (w_q - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (y > hi) begin
            shift_sat = hi;
        end else if (y < lo) begin
            shift_sat = lo;
        end else begin
            shift_sat = y;
        end
    endfunction

endpackage

// File: rtl/mat_result_serializer_if.sv
// Row-beat stream from the result serializer to its consumer (valid/ready).
interface mat_result_serializer_if #(
    parameter int N   = 8,
    parameter int W_Q = 8
) ();
    localparam int RW = (N > 1) ? $clog2(N) : 1;

    logic             out_valid;
    logic             out_ready;
    logic [N*W_Q-1:0] out_data;
    logic [RW-1:0]    out_row;
    logic             out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_row,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_row,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/requant_sat.sv
// One-element requantizer: arithmetic right shift followed by signed saturation.
module requant_sat
    import simd_pkg::*;
#(
    parameter int W_OUT = 32,
    parameter int W_Q   = 8,
    parameter int SHIFT = 0
) (
    input  logic [W_OUT-1:0] x,
    output logic [W_Q-1:0]   y
);
    logic signed [SAT_MAX_W-1:0] x_ext;

    assign x_ext = SAT_MAX_W'($signed(x));
    assign y     = W_Q'(shift_sat(x_ext, SHIFT, W_Q));
endmodule

// File: rtl/mat_result_serializer.sv
// Captures an NxN result matrix on a valid_in pulse and streams it out one
// requantized row per beat; results arriving while busy are dropped and flagged.
module mat_result_serializer
    import simd_pkg::*;
#(
    parameter int W_OUT = 32,
    parameter int W_Q   = 8,
    parameter int N     = 8,
    parameter int SHIFT = 0
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   valid_in,
    input  logic [N*N*W_OUT-1:0]   result,
    output logic                   in_ready,
    output logic                   drop_err,
    mat_result_serializer_if.master out_if
);
    localparam int RW    = (N > 1) ? $clog2(N) : 1;
    localparam int ROW_W = N * W_OUT;

    ser_state_e           state_q, state_d;
    logic [RW-1:0]        row_cnt_q, row_cnt_d;
    logic [N*N*W_OUT-1:0] buf_q, buf_d;
    logic                 drop_err_q, drop_err_d;

    logic                 row_last;
    logic                 beat;
    logic [ROW_W-1:0]     row_sel;
    logic [N*W_Q-1:0]     row_q;

    assign row_last = (row_cnt_q == RW'(N - 1));
    assign beat     = (state_q == SEND) && out_if.out_ready;
    // Accepting the last row frees the buffer in the same cycle, so a new
    // matrix can land with no idle bubble.
    assign in_ready = (state_q == IDLE) || (beat && row_last);

    always_comb begin
        state_d    = state_q;
        row_cnt_d  = row_cnt_q;
        buf_d      = buf_q;
        drop_err_d = drop_err_q | (valid_in & ~in_ready);
        unique case (state_q)
            IDLE: begin
                if (valid_in) begin
                    buf_d     = result;
                    row_cnt_d = '0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (out_if.out_ready) begin
                    if (!row_last) begin
                        row_cnt_d = row_cnt_q + RW'(1);
                    end else if (valid_in) begin
                        buf_d     = result;
                        row_cnt_d = '0;
                    end else begin
                        row_cnt_d = '0;
                        state_d   = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            row_cnt_q  <= '0;
            buf_q      <= '0;
            drop_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_cnt_q  <= row_cnt_d;
            buf_q      <= buf_d;
            drop_err_q <= drop_err_d;
        end
    end

    assign row_sel = buf_q[int'(row_cnt_q)*ROW_W +: ROW_W];

    for (genvar c = 0; c < N; c++) begin : g_col
        requant_sat #(
            .W_OUT (W_OUT),
            .W_Q   (W_Q),
            .SHIFT (SHIFT)
        ) u_requant (
            .x (row_sel[c*W_OUT +: W_OUT]),
            .y (row_q[c*W_Q +: W_Q])
        );
    end

    assign out_if.out_valid = (state_q == SEND);
    assign out_if.out_data  = row_q;
    assign out_if.out_row   = row_cnt_q;
    assign out_if.out_last  = (state_q == SEND) && row_last;
    assign drop_err         = drop_err_q;
endmodule

// File: tb/tb_mat_result_serializer.sv
// Scoreboard bench for mat_result_serializer: stimulus pushes expected rows,
// negedge monitors pop and compare every accepted beat.
module tb_mat_result_serializer;
    localparam int N     = 8;
    localparam int W_OUT = 32;
    localparam int W_Q   = 8;

    logic                 clk = 1'b0;
    logic                 resetn = 1'b0;
    logic                 valid_in = 1'b0;
    logic                 valid_in2 = 1'b0;
    logic [N*N*W_OUT-1:0] result = '0;
    logic [N*N*W_OUT-1:0] result2 = '0;
    logic                 in_ready, in_ready2;
    logic                 drop_err, drop_err2;

    mat_result_serializer_if #(.N(N), .W_Q(W_Q)) oif ();
    mat_result_serializer_if #(.N(N), .W_Q(W_Q)) oif2 ();

    mat_result_serializer #(.W_OUT(W_OUT), .W_Q(W_Q), .N(N), .SHIFT(0)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .valid_in (valid_in),
        .result   (result),
        .in_ready (in_ready),
        .drop_err (drop_err),
        .out_if   (oif)
    );

    mat_result_serializer #(.W_OUT(W_OUT), .W_Q(W_Q), .N(N), .SHIFT(4)) dut_sh4 (
        .clk      (clk),
        .resetn   (resetn),
        .valid_in (valid_in2),
        .result   (result2),
        .in_ready (in_ready2),
        .drop_err (drop_err2),
        .out_if   (oif2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N*W_Q-1:0] data;
        int               row;
        bit               last;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Input element for matrix pattern id at (r,c).
    function automatic longint elem_in(input int id, input int r, input int c);
        longint t2[8];
        longint t4[8];
        t2 = '{300, -300, 127, -128, 128, -129, 0, 0};
        t2[6] = r;
        t2[7] = -r;
        t4 = '{261, -17, 16, -1, 2047, -2048, 2048, -2064};
        case (id)
            1:       return 10 * r + c;
            2:       return t2[c];
            3:       return -(10 * r + c);
            default: return t4[c];
        endcase
    endfunction

    // Hand-derived requantized values for the same patterns.
    function automatic longint elem_exp(input int id, input int r, input int c);
        longint e2[8];
        longint e4[8];
        e2 = '{127, -128, 127, -128, 127, -128, 0, 0};
        e2[6] = r;
        e2[7] = -r;
        e4 = '{16, -2, 1, -1, 127, -128, 127, -128};
        case (id)
            1:       return 10 * r + c;
            2:       return e2[c];
            3:       return -(10 * r + c);
            default: return e4[c];
        endcase
    endfunction

    function automatic logic [N*N*W_OUT-1:0] build(input int id);
        logic [N*N*W_OUT-1:0] m;
        m = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                m[(r*N+c)*W_OUT +: W_OUT] = W_OUT'(elem_in(id, r, c));
        return m;
    endfunction

    function automatic exp_t exp_row(input int id, input int r);
        exp_t e;
        e.data = '0;
        for (int c = 0; c < N; c++)
            e.data[c*W_Q +: W_Q] = W_Q'(elem_exp(id, r, c));
        e.row  = r;
        e.last = (r == N - 1);
        return e;
    endfunction

    task automatic pulse1(input int id, input bit captured);
        @(posedge clk); #1;
        result   = build(id);
        valid_in = 1'b1;
        if (captured)
            for (int r = 0; r < N; r++) q1.push_back(exp_row(id, r));
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic pulse2(input int id);
        @(posedge clk); #1;
        result2   = build(id);
        valid_in2 = 1'b1;
        for (int r = 0; r < N; r++) q2.push_back(exp_row(id, r));
        @(posedge clk); #1;
        valid_in2 = 1'b0;
    endtask

    task automatic drain1(input int budget, input bit rnd);
        int k = 0;
        while (q1.size() != 0 && k < budget) begin
            @(posedge clk); #1;
            if (rnd) oif.out_ready = 1'($urandom_range(0, 1));
            k++;
        end
        oif.out_ready = 1'b1;
        chk("drain1_timeout", q1.size() == 0, 64'(q1.size()), 64'd0);
    endtask

    task automatic drain2(input int budget);
        int k = 0;
        while (q2.size() != 0 && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        chk("drain2_timeout", q2.size() == 0, 64'(q2.size()), 64'd0);
    endtask

    exp_t             e1, e2;
    logic [N*W_Q-1:0] hd1, hd2;
    int               hr1, hr2;
    bit               hl1, hl2;
    bit               hold1 = 1'b0, hold2 = 1'b0;

    always @(negedge clk) begin
        if (!resetn) begin
            hold1 = 1'b0;
        end else begin
            if (hold1)
                chk("hold_stable", oif.out_valid && oif.out_data == hd1 &&
                    int'(oif.out_row) == hr1 && oif.out_last == hl1,
                    {oif.out_data[55:0], 4'(oif.out_row), 3'd0, oif.out_valid},
                    {hd1[55:0], 4'(hr1), 3'd0, 1'b1});
            if (oif.out_valid && oif.out_ready) begin
                if (q1.size() == 0) begin
                    chk("unexpected_beat", 1'b0, 64'(oif.out_row), 64'd0);
                end else begin
                    e1 = q1.pop_front();
                    chk("row_data", oif.out_data == e1.data, oif.out_data, e1.data);
                    chk("row_index", int'(oif.out_row) == e1.row, 64'(oif.out_row), 64'(e1.row));
                    chk("row_last", oif.out_last == e1.last, 64'(oif.out_last), 64'(e1.last));
                end
            end
            hold1 = oif.out_valid && !oif.out_ready;
            hd1   = oif.out_data;
            hr1   = int'(oif.out_row);
            hl1   = oif.out_last;
        end
    end

    always @(negedge clk) begin
        if (!resetn) begin
            hold2 = 1'b0;
        end else begin
            if (hold2)
                chk("sh4_hold_stable", oif2.out_valid && oif2.out_data == hd2 &&
                    int'(oif2.out_row) == hr2 && oif2.out_last == hl2,
                    oif2.out_data, hd2);
            if (oif2.out_valid && oif2.out_ready) begin
                if (q2.size() == 0) begin
                    chk("sh4_unexpected_beat", 1'b0, 64'(oif2.out_row), 64'd0);
                end else begin
                    e2 = q2.pop_front();
                    chk("sh4_row_data", oif2.out_data == e2.data, oif2.out_data, e2.data);
                    chk("sh4_row_index", int'(oif2.out_row) == e2.row, 64'(oif2.out_row), 64'(e2.row));
                    chk("sh4_row_last", oif2.out_last == e2.last, 64'(oif2.out_last), 64'(e2.last));
                end
            end
            hold2 = oif2.out_valid && !oif2.out_ready;
            hd2   = oif2.out_data;
            hr2   = int'(oif2.out_row);
            hl2   = oif2.out_last;
        end
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: simulation did not finish, n_err %0d", n_err);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        oif.out_ready  = 1'b1;
        oif2.out_ready = 1'b1;

        // Reset values
        #3;
        chk("rst_in_ready", in_ready == 1'b1, 64'(in_ready), 64'd1);
        chk("rst_out_valid", oif.out_valid == 1'b0, 64'(oif.out_valid), 64'd0);
        chk("rst_out_row", oif.out_row == '0, 64'(oif.out_row), 64'd0);
        chk("rst_out_last", oif.out_last == 1'b0, 64'(oif.out_last), 64'd0);
        chk("rst_out_data", oif.out_data == '0, oif.out_data, 64'd0);
        chk("rst_drop_err", drop_err == 1'b0, 64'(drop_err), 64'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        // Basic stream, timing of first/last row
        pulse1(1, 1'b1);
        chk("lat_valid", oif.out_valid == 1'b1, 64'(oif.out_valid), 64'd1);
        chk("lat_row0", oif.out_row == '0, 64'(oif.out_row), 64'd0);
        repeat (N - 1) begin @(posedge clk); #1; end
        chk("row7_last", oif.out_last == 1'b1 && oif.out_row == 3'd7, 64'({oif.out_last, oif.out_row}), 64'h0f);
        @(posedge clk); #1;
        chk("end_valid_low", oif.out_valid == 1'b0, 64'(oif.out_valid), 64'd0);
        chk("end_q_empty", q1.size() == 0, 64'(q1.size()), 64'd0);

        // Saturation, SHIFT=0
        pulse1(2, 1'b1);
        drain1(40, 1'b0);

        // Shift then saturate, SHIFT=4
        pulse2(4);
        drain2(40);

        // Random backpressure
        pulse1(1, 1'b1);
        drain1(400, 1'b1);
        @(posedge clk); #1;
        chk("bp_idle", oif.out_valid == 1'b0, 64'(oif.out_valid), 64'd0);

        // Back-to-back capture on the last row
        pulse1(1, 1'b1);
        repeat (N - 2) begin @(posedge clk); #1; end
        chk("b2b_busy", in_ready == 1'b0, 64'(in_ready), 64'd0);
        pulse1(3, 1'b1);
        chk("b2b_row0", oif.out_valid == 1'b1 && oif.out_row == '0, 64'({oif.out_valid, oif.out_row}), 64'h08);
        drain1(40, 1'b0);
        chk("b2b_no_drop", drop_err == 1'b0, 64'(drop_err), 64'd0);

        // Overflow while row 2 is stalled
        oif.out_ready = 1'b0;
        pulse1(1, 1'b1);
        oif.out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        oif.out_ready = 1'b0;
        chk("ovf_row2", oif.out_row == 3'd2, 64'(oif.out_row), 64'd2);
        chk("ovf_busy", in_ready == 1'b0, 64'(in_ready), 64'd0);
        pulse1(3, 1'b0);
        chk("ovf_drop_set", drop_err == 1'b1, 64'(drop_err), 64'd1);
        chk("ovf_still_row2", oif.out_row == 3'd2, 64'(oif.out_row), 64'd2);
        oif.out_ready = 1'b1;
        drain1(40, 1'b0);
        chk("ovf_drop_sticky", drop_err == 1'b1, 64'(drop_err), 64'd1);

        // Reset while row 4 is presented
        pulse1(1, 1'b1);
        repeat (4) begin @(posedge clk); #1; end
        chk("mid_row4", oif.out_row == 3'd4, 64'(oif.out_row), 64'd4);
        resetn = 1'b0;
        #1;
        chk("mid_rst_valid", oif.out_valid == 1'b0, 64'(oif.out_valid), 64'd0);
        chk("mid_rst_drop", drop_err == 1'b0, 64'(drop_err), 64'd0);
        chk("mid_rst_row", oif.out_row == '0, 64'(oif.out_row), 64'd0);
        q1.delete();
        @(posedge clk); #1;
        resetn = 1'b1;
        chk("post_rst_in_ready", in_ready == 1'b1, 64'(in_ready), 64'd1);
        pulse1(2, 1'b1);
        chk("post_rst_row0", oif.out_valid == 1'b1 && oif.out_row == '0, 64'({oif.out_valid, oif.out_row}), 64'h08);
        drain1(40, 1'b0);

        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
